// File: rtl/seg7_frame_scheduler.sv
// Serialises six 7-segment digit codes plus decimal points into one 48-bit frame,
// shifts it MSB first to cascaded shift registers and pulses the storage latch.
module seg7_frame_scheduler #(
  parameter int CLK_DIV        = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_en,
  input  logic       i_update,
  input  logic [6:0] i_hours_msb,
  input  logic [6:0] i_hours_lsb,
  input  logic [6:0] i_minutes_msb,
  input  logic [6:0] i_minutes_lsb,
  input  logic [6:0] i_seconds_msb,
  input  logic [6:0] i_seconds_lsb,
  input  logic [5:0] i_dp,
  output logic       o_serial_data,
  output logic       o_serial_clk,
  output logic       o_serial_latch,
  output logic       o_busy,
  output logic       o_done
);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("seg7_frame_scheduler: CLK_DIV must be in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HIGH  = 2'd2,
    S_LATCH = 2'd3
  } state_e;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bit_q, bit_d;
  logic [47:0] shreg_q, shreg_d;
  logic        pending_q, pending_d;
  logic        data_q, data_d;
  logic        sclk_q, sclk_d;
  logic        latch_q, latch_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [47:0] frame_w;
  logic        start_w;
  logic        div_done_w;
  logic        last_bit_w;

  // i_update is a single-cycle request strobe with no ready: a request that cannot
  // start a frame right now is remembered in pending_q, and any number of such
  // requests collapse into one frame carrying the inputs present at its start.
  assign frame_w = {i_dp[5], i_hours_msb,   i_dp[4], i_hours_lsb,
                    i_dp[3], i_minutes_msb, i_dp[2], i_minutes_lsb,
                    i_dp[1], i_seconds_msb, i_dp[0], i_seconds_lsb}
                   ^ {48{SEG_ACTIVE_LOW}};

  assign start_w    = (state_q == S_IDLE) && i_en && (i_update || pending_q);
  assign div_done_w = (div_q == 8'd0);
  assign last_bit_w = (bit_q == 6'd0);

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_w)    state_d = S_SETUP;
      S_SETUP: if (div_done_w) state_d = S_HIGH;
      S_HIGH:  if (div_done_w) state_d = last_bit_w ? S_LATCH : S_SETUP;
      S_LATCH: if (div_done_w) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: divider reloads on every state entry, shift only on HIGH->SETUP
  always_comb begin
    div_d     = div_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    pending_d = pending_q;

    if (state_d == S_IDLE) begin
      div_d = 8'd0;
    end else if (state_d != state_q) begin
      div_d = DIV_LOAD;
    end else if (!div_done_w) begin
      div_d = div_q - 8'd1;
    end

    if (start_w) begin
      shreg_d = frame_w;
      bit_d   = 6'd47;
    end else if ((state_q == S_HIGH) && div_done_w && !last_bit_w) begin
      shreg_d = {shreg_q[46:0], 1'b0};
      bit_d   = bit_q - 6'd1;
    end

    if (start_w) begin
      pending_d = 1'b0;
    end else if (i_update) begin
      pending_d = 1'b1;
    end
  end

  // Output logic: pins are computed from the upcoming state and registered
  always_comb begin
    data_d  = 1'b0;
    sclk_d  = 1'b0;
    latch_d = 1'b0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_LATCH) && (state_d == S_IDLE);
    case (state_d)
      S_SETUP: data_d = shreg_d[47];
      S_HIGH: begin
        data_d = shreg_d[47];
        sclk_d = 1'b1;
      end
      S_LATCH: latch_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_q     <= 8'd0;
      bit_q     <= 6'd0;
      shreg_q   <= 48'd0;
      pending_q <= 1'b0;
      data_q    <= 1'b0;
      sclk_q    <= 1'b0;
      latch_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      sclk_q    <= sclk_d;
      latch_q   <= latch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_serial_data  = data_q;
  assign o_serial_clk   = sclk_q;
  assign o_serial_latch = latch_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_seg7_frame_scheduler.sv
// Bench for seg7_frame_scheduler: two instances (CLK_DIV=2 active-high, CLK_DIV=1
// active-low) checked cycle by cycle against a frame-level reference model.
module tb_seg7_frame_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en   [2];
  logic       upd  [2];
  logic [6:0] dig  [2][6];
  logic [5:0] dp   [2];
  logic       sdata  [2];
  logic       sclk   [2];
  logic       slatch [2];
  logic       busy   [2];
  logic       done   [2];

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  seg7_frame_scheduler #(.CLK_DIV(2), .SEG_ACTIVE_LOW(1'b0)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en[0]), .i_update(upd[0]),
    .i_hours_msb(dig[0][0]), .i_hours_lsb(dig[0][1]),
    .i_minutes_msb(dig[0][2]), .i_minutes_lsb(dig[0][3]),
    .i_seconds_msb(dig[0][4]), .i_seconds_lsb(dig[0][5]),
    .i_dp(dp[0]), .o_serial_data(sdata[0]), .o_serial_clk(sclk[0]),
    .o_serial_latch(slatch[0]), .o_busy(busy[0]), .o_done(done[0])
  );

  seg7_frame_scheduler #(.CLK_DIV(1), .SEG_ACTIVE_LOW(1'b1)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en[1]), .i_update(upd[1]),
    .i_hours_msb(dig[1][0]), .i_hours_lsb(dig[1][1]),
    .i_minutes_msb(dig[1][2]), .i_minutes_lsb(dig[1][3]),
    .i_seconds_msb(dig[1][4]), .i_seconds_lsb(dig[1][5]),
    .i_dp(dp[1]), .o_serial_data(sdata[1]), .o_serial_clk(sclk[1]),
    .o_serial_latch(slatch[1]), .o_busy(busy[1]), .o_done(done[1])
  );

  function automatic int div_of(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [47:0] ref_frame(int k);
    logic [47:0] f = '0;
    for (int i = 0; i < 6; i++) f = {f[39:0], dp[k][5-i], dig[k][i]};
    return (k == 1) ? ~f : f;
  endfunction

  int          cnt       [2] = '{0, 0};
  bit          pend      [2] = '{0, 0};
  bit          exp_done  [2] = '{0, 0};
  int          start_cyc [2] = '{0, 0};
  int          cyc = 0;
  logic [47:0] exp_q [2][$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        cnt[k] = 0; pend[k] = 0; exp_done[k] = 0;
      end
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        bit idle;
        idle        = (cnt[k] == 0);
        exp_done[k] = (cnt[k] == 1);
        if (cnt[k] > 0) cnt[k]--;
        if (idle && en[k] && (upd[k] || pend[k])) begin
          exp_q[k].push_back(ref_frame(k));
          cnt[k]       = 97 * div_of(k);
          pend[k]      = 0;
          start_cyc[k] = cyc;
        end else if (upd[k]) begin
          pend[k] = 1;
        end
      end
    end
  end

  // ---------------- scoreboard / pin monitor ----------------
  logic        prev_sclk [2], prev_latch [2], prev_busy [2], held [2];
  int          nb [2], lat_len [2], rd_idx [2];
  int          lat_cnt [2] = '{0, 0};
  logic [47:0] got [2], last_frame [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        prev_sclk[k] = 0; prev_latch[k] = 0; prev_busy[k] = 0;
        nb[k] = 0; lat_len[k] = 0; got[k] = '0;
        rd_idx[k] = exp_q[k].size();
      end else begin
        check($sformatf("busy%0d", k), 48'(busy[k]), 48'(cnt[k] > 0));
        check($sformatf("done%0d", k), 48'(done[k]), 48'(exp_done[k]));
        if (done[k] && exp_done[k])
          check($sformatf("done_latency%0d", k), 48'(cyc - start_cyc[k]), 48'(97 * div_of(k)));
        if (cnt[k] == 0)
          check($sformatf("idle_pins%0d", k), 48'({sclk[k], slatch[k], sdata[k]}), 48'd0);
        if (slatch[k])
          check($sformatf("latch_pins%0d", k), 48'({sclk[k], sdata[k]}), 48'd0);
        if (busy[k] && !prev_busy[k] && rd_idx[k] < exp_q[k].size()) begin
          logic [47:0] f;
          f = exp_q[k][exp_q[k].size() - 1];
          check($sformatf("first_bit%0d", k), 48'(sdata[k]), 48'(f[47]));
        end
        if (sclk[k] && !prev_sclk[k]) begin
          got[k]  = {got[k][46:0], sdata[k]};
          nb[k]++;
          held[k] = sdata[k];
        end else if (sclk[k]) begin
          check($sformatf("data_hold%0d", k), 48'(sdata[k]), 48'(held[k]));
        end
        if (slatch[k] && !prev_latch[k]) begin
          check($sformatf("nbits%0d", k), 48'(nb[k]), 48'd48);
          check($sformatf("frame_expected%0d", k), 48'(rd_idx[k] < exp_q[k].size()), 48'd1);
          if (rd_idx[k] < exp_q[k].size()) begin
            check($sformatf("frame%0d", k), got[k], exp_q[k][rd_idx[k]]);
            rd_idx[k]++;
          end
          last_frame[k] = got[k];
          nb[k] = 0;
          lat_len[k] = 0;
          lat_cnt[k]++;
        end
        if (slatch[k]) lat_len[k]++;
        if (!slatch[k] && prev_latch[k])
          check($sformatf("latch_len%0d", k), 48'(lat_len[k]), 48'(div_of(k)));
        prev_sclk[k]  = sclk[k];
        prev_latch[k] = slatch[k];
        prev_busy[k]  = busy[k];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int k);
    upd[k] = 1'b1;
    tick(1);
    upd[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    for (int i = 0; i < 2000; i++) begin
      if (!busy[k]) break;
      tick(1);
    end
    check($sformatf("idle_wait%0d", k), 48'(busy[k]), 48'd0);
  endtask

  task automatic wait_bits(input int k, input int n);
    for (int i = 0; i < 2000; i++) begin
      if (nb[k] >= n) break;
      tick(1);
    end
    check($sformatf("bit_wait%0d", k), 48'(nb[k]), 48'(n));
  endtask

  task automatic rand_digits(input int k);
    for (int i = 0; i < 6; i++) dig[k][i] = 7'($urandom_range(0, 127));
    dp[k] = 6'($urandom_range(0, 63));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      en[k] = 1'b0; upd[k] = 1'b0; dp[k] = '0;
      for (int i = 0; i < 6; i++) dig[k][i] = '0;
    end
    tick(3);
    for (int k = 0; k < 2; k++)
      check($sformatf("reset_outs%0d", k),
            48'({sdata[k], sclk[k], slatch[k], busy[k], done[k]}), 48'd0);
    rst_n = 1'b1;
    tick(2);

    // single digit pattern, CLK_DIV=2
    dig[0][0] = 7'h06;
    en[0] = 1'b1;
    pulse(0);
    wait_idle(0);
    check("tp1_frame", last_frame[0], 48'h06_00_00_00_00_00);
    tick(3);

    // all segments lit, active-low, CLK_DIV=1
    for (int i = 0; i < 6; i++) dig[1][i] = 7'h7F;
    dp[1] = 6'b101010;
    en[1] = 1'b1;
    pulse(1);
    wait_idle(1);
    check("tp2_frame", last_frame[1], 48'h00_80_00_80_00_80);
    tick(3);

    // requests during a busy frame collapse into one follow-on frame
    base = lat_cnt[0];
    rand_digits(0);
    pulse(0);
    tick(20);
    repeat (3) begin
      pulse(0);
      tick(30);
    end
    rand_digits(0);
    wait_idle(0);
    tick(1);
    wait_idle(0);
    tick(20);
    check("tp3_frames", 48'(lat_cnt[0] - base), 48'd2);

    // disabled request is held until enable rises
    en[0] = 1'b0;
    rand_digits(0);
    pulse(0);
    tick(10);
    check("tp4_quiet", 48'(busy[0]), 48'd0);
    en[0] = 1'b1;
    tick(1);
    check("tp4_start", 48'(busy[0]), 48'd1);
    wait_idle(0);
    tick(3);

    // enable dropped mid-frame: frame completes, nothing new starts
    base = lat_cnt[1];
    rand_digits(1);
    pulse(1);
    wait_bits(1, 20);
    en[1] = 1'b0;
    wait_idle(1);
    tick(20);
    check("tp5_frames", 48'(lat_cnt[1] - base), 48'd1);
    en[1] = 1'b1;

    // reset mid-frame: pins drop at once, no latch afterwards
    base = lat_cnt[0];
    rand_digits(0);
    pulse(0);
    wait_bits(0, 30);
    pulse(0);
    rst_n = 1'b0;
    #1;
    check("tp6_reset_pins",
          48'({sdata[0], sclk[0], slatch[0], busy[0], done[0]}), 48'd0);
    tick(2);
    rst_n = 1'b1;
    tick(30);
    check("tp6_no_latch", 48'(lat_cnt[0] - base), 48'd0);
    check("tp6_idle", 48'(busy[0]), 48'd0);

    // randomized traffic on both instances
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 2; k++) begin
        upd[k] = ($urandom_range(0, 40) == 0);
        if ($urandom_range(0, 200) == 0) en[k] = ~en[k];
        if ($urandom_range(0, 50) == 0) rand_digits(k);
      end
      tick(1);
    end
    for (int k = 0; k < 2; k++) begin
      upd[k] = 1'b0;
      en[k]  = 1'b0;
    end
    tick(1);
    wait_idle(0);
    wait_idle(1);
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
